// File: rtl/dmem_pkg.sv
// Package: dmem_pkg
// Shared defaults and types for the data-memory bank read port.
//   DMEM_DATA_W : default word width in bits
//   DMEM_ADDR_W : default address width in bits
//   dmem_word_t : one data word at the default width
//   rd_state_e  : state of the registered read-output stage (exported for debug)
package dmem_pkg;
  localparam int DMEM_DATA_W = 16;
  localparam int DMEM_ADDR_W = 4;

  typedef logic [DMEM_DATA_W-1:0] dmem_word_t;

  // RD_EMPTY: output register holds nothing; RD_FULL: holds a completed read.
  typedef enum logic {
    RD_EMPTY = 1'b0,
    RD_FULL  = 1'b1
  } rd_state_e;
endpackage

// File: rtl/dmem_bank_rdport_if.sv
// Interface: dmem_bank_rdport_if
// Bundles the write port and the valid/ready read port of the data-memory bank.
//   wr_en/wr_addr/wr_data : write strobe, address, data (never stalls)
//   rd_req/rd_addr        : read request and address
//   rd_rdy                : bank can accept a read this cycle
//   rd_valid/rd_data/rd_err : completed read held in the output register
//   rd_ack                : consumer takes the held result this cycle
// Handshake: a read is accepted on a rising edge where rd_req && rd_rdy.
// A result is consumed on a rising edge where rd_valid && rd_ack; while
// rd_valid is high and rd_ack is low, rd_data/rd_err are held stable and
// rd_rdy is low. rd_ack with rd_valid low has no effect.
// Modports: master = load/store unit side, slave = memory bank side.
interface dmem_bank_rdport_if
  import dmem_pkg::*;
#(
  parameter int DATA_W = DMEM_DATA_W,
  parameter int ADDR_W = DMEM_ADDR_W
);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_rdy;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              rd_err;
  logic              rd_ack;

  modport master (
    output wr_en, wr_addr, wr_data, rd_req, rd_addr, rd_ack,
    input  rd_rdy, rd_valid, rd_data, rd_err
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_req, rd_addr, rd_ack,
    output rd_rdy, rd_valid, rd_data, rd_err
  );
endinterface

// File: rtl/dmem_rd_mux.sv
// Module: dmem_rd_mux
// Combinational DEPTH:1 word select for the bank read path.
//   words : storage array (DEPTH words of DATA_W bits)
//   addr  : read address
//   word  : selected word, or zero when addr >= DEPTH
//   oor   : addr is outside the implemented words
module dmem_rd_mux #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 16
) (
  input  logic [DATA_W-1:0] words [DEPTH],
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] word,
  output logic              oor
);
  // Compare against each index rather than indexing directly so that a
  // DEPTH that is not a power of two never reads past the array.
  always_comb begin
    word = '0;
    oor  = (int'(addr) >= DEPTH);
    for (int i = 0; i < DEPTH; i++) begin
      if (int'(addr) == i) word = words[i];
    end
  end
endmodule

// File: rtl/dmem_bank_rdport.sv
// Module: dmem_bank_rdport
// Parametrised data-memory bank (DEPTH x DATA_W) with one write port and one
// registered, valid/ready-handshaked read port with 1-cycle latency.
//   clk       : rising-edge clock
//   rst       : synchronous active-high reset (clears all words to RST_VAL,
//               drops any held read result)
//   bus       : dmem_bank_rdport_if.slave (write port + read handshake)
//   dbg_state : current state of the read-output register
// Build option: define DMEM_RD_BYPASS_EN to forward same-cycle write data to
// a read of the same address; otherwise the read sees the pre-write word.
module dmem_bank_rdport
  import dmem_pkg::*;
#(
  parameter int                DATA_W  = DMEM_DATA_W,
  parameter int                ADDR_W  = DMEM_ADDR_W,
  parameter int                DEPTH   = 16,
  parameter logic [DATA_W-1:0] RST_VAL = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  dmem_bank_rdport_if.slave    bus,
  output rd_state_e            dbg_state
);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] rd_next;
  logic              rd_oor;
  logic [DATA_W-1:0] data_q;
  logic              err_q;
  rd_state_e         state;
  logic              accept;

  // Storage: out-of-range writes are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= RST_VAL;
    end else if (bus.wr_en && int'(bus.wr_addr) < DEPTH) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (int'(bus.wr_addr) == i) mem[i] <= bus.wr_data;
      end
    end
  end

  dmem_rd_mux #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_rd_mux (
    .words (mem),
    .addr  (bus.rd_addr),
    .word  (rd_word),
    .oor   (rd_oor)
  );

  // Same-cycle write/read collision handling.
  always_comb begin
    rd_next = rd_word;
`ifdef DMEM_RD_BYPASS_EN
    if (bus.wr_en && !rd_oor && bus.wr_addr == bus.rd_addr) rd_next = bus.wr_data;
`endif
  end

  assign bus.rd_rdy = (state == RD_EMPTY) || bus.rd_ack;
  assign accept     = bus.rd_req && bus.rd_rdy;

  // Output register: a held result is only replaced or dropped when acked.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= RD_EMPTY;
      data_q <= '0;
      err_q  <= 1'b0;
    end else begin
      case (state)
        RD_EMPTY: begin
          if (accept) begin
            state  <= RD_FULL;
            data_q <= rd_next;
            err_q  <= rd_oor;
          end
        end
        RD_FULL: begin
          if (bus.rd_ack) begin
            if (accept) begin
              data_q <= rd_next;
              err_q  <= rd_oor;
            end else begin
              state <= RD_EMPTY;
            end
          end
        end
        default: state <= RD_EMPTY;
      endcase
    end
  end

  assign bus.rd_valid = (state == RD_FULL);
  assign bus.rd_data  = data_q;
  assign bus.rd_err   = err_q;
  assign dbg_state    = state;
endmodule

// File: tb/tb_dmem_bank_rdport.sv
// Testbench for dmem_bank_rdport (DEPTH=12 so out-of-range reads are reachable).
module tb_dmem_bank_rdport;
  import dmem_pkg::*;

  localparam int DEPTH = 12;

  logic      clk;
  logic      rst;
  rd_state_e dbg_state;

  dmem_bank_rdport_if #(.DATA_W(16), .ADDR_W(4)) bus ();

  dmem_bank_rdport #(
    .DATA_W  (16),
    .ADDR_W  (4),
    .DEPTH   (DEPTH),
    .RST_VAL (16'h0000)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model + scoreboard ----------------
  // exp_q holds {err, data} of results produced but not yet consumed.
  logic [15:0] m_mem [16];
  logic [16:0] exp_q [$];
  int          n_vec;
  int          n_err;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // One clock: check outputs at the falling edge, advance the model with the
  // current inputs, then return #1 after the rising edge.
  task automatic tick();
    logic [16:0] res;
    bit          valid;
    bit          rdy;
    bit          acc;
    @(negedge clk);
    valid = (exp_q.size() != 0);
    rdy   = !valid || bus.rd_ack;
    chk("rd_valid", 32'(bus.rd_valid), 32'(valid));
    chk("rd_rdy", 32'(bus.rd_rdy), 32'(rdy));
    if (valid) begin
      chk("rd_data", 32'(bus.rd_data), 32'(exp_q[0][15:0]));
      chk("rd_err", 32'(bus.rd_err), 32'(exp_q[0][16]));
    end
    if (rst) begin
      for (int i = 0; i < 16; i++) m_mem[i] = 16'h0000;
      exp_q.delete();
    end else begin
      acc = bus.rd_req && rdy;
      res = '0;
      if (acc) begin
        if (int'(bus.rd_addr) >= DEPTH) begin
          res = {1'b1, 16'h0000};
        end else begin
          res = {1'b0, m_mem[bus.rd_addr]};
`ifdef DMEM_RD_BYPASS_EN
          if (bus.wr_en && bus.wr_addr == bus.rd_addr) res = {1'b0, bus.wr_data};
`endif
        end
      end
      if (valid && bus.rd_ack) void'(exp_q.pop_front());
      if (acc) exp_q.push_back(res);
      if (bus.wr_en && int'(bus.wr_addr) < DEPTH) m_mem[bus.wr_addr] = bus.wr_data;
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle();
    bus.wr_en   = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.rd_req  = 1'b0;
    bus.rd_addr = '0;
    bus.rd_ack  = 1'b1;
  endtask

  task automatic do_write(input logic [3:0] a, input logic [15:0] d);
    idle();
    bus.wr_en   = 1'b1;
    bus.wr_addr = a;
    bus.wr_data = d;
    tick();
    idle();
  endtask

  task automatic do_read(input logic [3:0] a);
    idle();
    bus.rd_req  = 1'b1;
    bus.rd_addr = a;
    tick();
    idle();
  endtask

  task automatic drain();
    idle();
    tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_vec = 0;
    n_err = 0;
    for (int i = 0; i < 16; i++) m_mem[i] = 16'h0000;
    idle();
    rst = 1'b1;
    @(posedge clk);
    #1;
    tick();
    rst = 1'b0;
    chk("rst_valid", 32'(bus.rd_valid), 32'd0);
    chk("rst_rdy", 32'(bus.rd_rdy), 32'd1);

    // 1: back-to-back reads of every address after reset
    bus.rd_ack = 1'b1;
    for (int a = 0; a < 16; a++) begin
      bus.rd_req  = 1'b1;
      bus.rd_addr = 4'(a);
      tick();
      chk("t1_valid", 32'(bus.rd_valid), 32'd1);
      chk("t1_data", 32'(bus.rd_data), 32'h0);
    end
    drain();

    // 2: write then read, 1-cycle latency
    do_write(4'd3, 16'hA5A5);
    do_read(4'd3);
    chk("t2_valid", 32'(bus.rd_valid), 32'd1);
    chk("t2_data", 32'(bus.rd_data), 32'hA5A5);
    drain();

    // 3: stall holds data across a write to the same word
    do_write(4'd7, 16'h1234);
    bus.rd_req  = 1'b1;
    bus.rd_addr = 4'd7;
    bus.rd_ack  = 1'b0;
    tick();
    for (int k = 0; k < 3; k++) begin
      bus.wr_en   = (k == 0);
      bus.wr_addr = 4'd7;
      bus.wr_data = 16'hFFFF;
      bus.rd_ack  = 1'b0;
      tick();
      chk("t3_hold", 32'(bus.rd_data), 32'h1234);
      chk("t3_rdy", 32'(bus.rd_rdy), 32'd0);
    end
    bus.wr_en  = 1'b0;
    bus.rd_ack = 1'b1;
    tick();
    chk("t3_new", 32'(bus.rd_data), 32'hFFFF);
    drain();

    // 4: same-cycle write/read collision
    do_write(4'd5, 16'h0001);
    bus.wr_en   = 1'b1;
    bus.wr_addr = 4'd5;
    bus.wr_data = 16'hBEEF;
    bus.rd_req  = 1'b1;
    bus.rd_addr = 4'd5;
    tick();
`ifdef DMEM_RD_BYPASS_EN
    chk("t4_coll", 32'(bus.rd_data), 32'hBEEF);
`else
    chk("t4_coll", 32'(bus.rd_data), 32'h0001);
`endif
    do_read(4'd5);
    chk("t4_after", 32'(bus.rd_data), 32'hBEEF);
    drain();

    // 5: out-of-range write dropped, out-of-range reads flag error
    do_write(4'd13, 16'h5555);
    do_read(4'd13);
    chk("t5_err", 32'(bus.rd_err), 32'd1);
    chk("t5_data", 32'(bus.rd_data), 32'h0);
    for (int a = 12; a < 16; a++) begin
      do_read(4'(a));
      chk("t5_no5555", 32'(bus.rd_data == 16'h5555), 32'd0);
    end
    drain();

    // random traffic, including occasional resets
    for (int n = 0; n < 400; n++) begin
      bus.wr_en   = 1'($urandom_range(0, 1));
      bus.wr_addr = 4'($urandom_range(0, 15));
      bus.wr_data = 16'($urandom);
      bus.rd_req  = 1'($urandom_range(0, 3) != 0);
      bus.rd_addr = ($urandom_range(0, 3) == 0) ? bus.wr_addr : 4'($urandom_range(0, 15));
      bus.rd_ack  = 1'($urandom_range(0, 2) != 0);
      rst         = ($urandom_range(0, 59) == 0);
      tick();
    end
    rst = 1'b0;
    drain();

    // 6: reset while a result is held unacked
    do_write(4'd2, 16'h7777);
    bus.rd_req  = 1'b1;
    bus.rd_addr = 4'd2;
    bus.rd_ack  = 1'b0;
    tick();
    chk("t6_held", 32'(bus.rd_valid), 32'd1);
    bus.rd_req = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_valid", 32'(bus.rd_valid), 32'd0);
    chk("t6_rdy", 32'(bus.rd_rdy), 32'd1);
    bus.rd_ack = 1'b1;
    for (int a = 0; a < DEPTH; a++) begin
      bus.rd_req  = 1'b1;
      bus.rd_addr = 4'(a);
      tick();
      chk("t6_rstval", 32'(bus.rd_data), 32'h0);
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
